// File: rtl/alu_chunked_seq.sv
// Sequential chunked ALU: AND/OR/ADD/SUB/SLT over WIDTH-bit operands, CHUNK bits per clock, LSB first.
// The ripple carry is held in a register between chunks; valid/ready handshake on input and output.
module alu_chunked_seq #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow,
  output logic             zero
);

  localparam int NCH = WIDTH / CHUNK;
  localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;

  generate
    if (WIDTH < 2 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_params
      $error("alu_chunked_seq: WIDTH must be >= 2 and a multiple of CHUNK");
    end
  endgenerate

  // FIN is the finishing cycle that applies SLT/illegal-op fix-ups, giving NCH+1 latency.
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN, S_DONE} state_t;

  state_t r_state;
  state_t w_state_next;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [2:0]       r_op;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_result;
  logic             r_cout;
  logic             r_ovf;
  logic             r_zero;
  logic             r_slt_bit;

  logic [CHUNK-1:0] w_bb;
  logic [CHUNK-1:0] w_sum;
  logic [CHUNK-1:0] w_and;
  logic [CHUNK-1:0] w_or;
  logic [CHUNK:0]   w_c;
  logic [CHUNK-1:0] w_res_chunk;
  logic [WIDTH-1:0] w_res_ext;
  logic [WIDTH-1:0] w_final;
  logic             w_legal;
  logic             w_arith;
  logic             w_is_slt;
  logic             w_last;
  logic             w_ovf_chunk;

  // Operands shift right each RUN cycle, so the active chunk is always the low CHUNK bits.
  assign w_c[0] = r_carry;
  generate
    for (genvar gi = 0; gi < CHUNK; gi++) begin : g_bit
      assign w_bb[gi]   = r_b[gi] ^ r_op[2];
      assign w_sum[gi]  = r_a[gi] ^ w_bb[gi] ^ w_c[gi];
      assign w_c[gi+1]  = (r_a[gi] & w_bb[gi]) | (w_c[gi] & (r_a[gi] ^ w_bb[gi]));
      assign w_and[gi]  = r_a[gi] & r_b[gi];
      assign w_or[gi]   = r_a[gi] | r_b[gi];
    end
  endgenerate

  always_comb begin
    w_res_chunk = w_sum;
    case (r_op[1:0])
      2'b00:   w_res_chunk = w_and;
      2'b01:   w_res_chunk = w_or;
      default: w_res_chunk = w_sum;
    endcase
  end

  assign w_legal     = (r_op == 3'b000) || (r_op == 3'b001) || (r_op == 3'b010) ||
                       (r_op == 3'b110) || (r_op == 3'b111);
  assign w_arith     = w_legal && r_op[1];
  assign w_is_slt    = (r_op == 3'b111);
  assign w_last      = (r_cnt == CW'(NCH - 1));
  assign w_ovf_chunk = w_c[CHUNK-1] ^ w_c[CHUNK];
  assign w_res_ext   = WIDTH'(w_res_chunk);

  always_comb begin
    w_final = r_result;
    if (!w_legal) begin
      w_final = '0;
    end else if (w_is_slt) begin
      w_final = WIDTH'(r_slt_bit);
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (in_valid) w_state_next = S_RUN;
      S_RUN:   if (w_last) w_state_next = S_FIN;
      S_FIN:   w_state_next = S_DONE;
      S_DONE:  if (out_ready) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a       <= '0;
      r_b       <= '0;
      r_op      <= '0;
      r_carry   <= 1'b0;
      r_cnt     <= '0;
      r_result  <= '0;
      r_cout    <= 1'b0;
      r_ovf     <= 1'b0;
      r_zero    <= 1'b0;
      r_slt_bit <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= b;
            r_op    <= op;
            r_carry <= op[2];
            r_cnt   <= '0;
          end
        end
        S_RUN: begin
          r_a      <= r_a >> CHUNK;
          r_b      <= r_b >> CHUNK;
          r_carry  <= w_c[CHUNK];
          r_cnt    <= r_cnt + CW'(1);
          // Result fills from the top; after NCH shifts chunk 0 sits at the LSBs.
          r_result <= (r_result >> CHUNK) | (w_res_ext << (WIDTH - CHUNK));
          if (w_last) begin
            r_cout    <= w_arith & w_c[CHUNK];
            r_ovf     <= w_arith & w_ovf_chunk;
            r_slt_bit <= w_sum[CHUNK-1] ^ w_ovf_chunk;
          end
        end
        S_FIN: begin
          r_result <= w_final;
          r_zero   <= (w_final == '0);
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign result    = r_result;
  assign cout      = r_cout;
  assign overflow  = r_ovf;
  assign zero      = r_zero;

endmodule

// File: tb/tb_alu_chunked_seq.sv
// Directed bench for alu_chunked_seq: an 8-bit/2-bit-chunk instance and an 8-bit/8-bit-chunk instance.
module tb_alu_chunked_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       in_valid0 = 1'b0, in_ready0, out_valid0, out_ready0 = 1'b0;
  logic [7:0] a0 = '0, b0 = '0, result0;
  logic [2:0] op0 = '0;
  logic       cout0, ovf0, zero0;

  logic       in_valid1 = 1'b0, in_ready1, out_valid1, out_ready1 = 1'b0;
  logic [7:0] a1 = '0, b1 = '0, result1;
  logic [2:0] op1 = '0;
  logic       cout1, ovf1, zero1;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  alu_chunked_seq #(.WIDTH(8), .CHUNK(2)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid0), .in_ready(in_ready0),
    .a(a0), .b(b0), .op(op0),
    .out_valid(out_valid0), .out_ready(out_ready0),
    .result(result0), .cout(cout0), .overflow(ovf0), .zero(zero0)
  );

  alu_chunked_seq #(.WIDTH(8), .CHUNK(8)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .op(op1),
    .out_valid(out_valid1), .out_ready(out_ready1),
    .result(result1), .cout(cout1), .overflow(ovf1), .zero(zero1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Runs one transaction on instance u; bp = cycles of output backpressure held in DONE.
  task automatic run_op(input int u, input logic [7:0] ta, input logic [7:0] tbv,
                        input logic [2:0] top, input logic [7:0] er, input logic ec,
                        input logic eo, input logic ez, input int elat, input int bp);
    int lat;
    bit done;
    logic [7:0] gr;
    logic gc, go, gz, gv, gi;
    if (u == 0) begin a0 = ta; b0 = tbv; op0 = top; in_valid0 = 1'b1; end
    else        begin a1 = ta; b1 = tbv; op1 = top; in_valid1 = 1'b1; end
    check("in_ready_before_accept", (u == 0) ? in_ready0 : in_ready1, 1);
    @(posedge clk); #1;
    // Scramble inputs after capture; the DUT must ignore them.
    if (u == 0) begin a0 = ~ta; b0 = ~tbv; op0 = 3'b000; in_valid0 = 1'b0; end
    else        begin a1 = ~ta; b1 = ~tbv; op1 = 3'b000; in_valid1 = 1'b0; end
    lat = 0;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(posedge clk); #1;
      lat++;
      if (((u == 0) ? out_valid0 : out_valid1) === 1'b1) done = 1'b1;
    end
    check("latency", lat, elat);
    gr = (u == 0) ? result0 : result1;
    gc = (u == 0) ? cout0 : cout1;
    go = (u == 0) ? ovf0 : ovf1;
    gz = (u == 0) ? zero0 : zero1;
    check("result", gr, er);
    check("cout", gc, ec);
    check("overflow", go, eo);
    check("zero", gz, ez);
    for (int i = 0; i < bp; i++) begin
      if (u == 0) begin in_valid0 = ~in_valid0; a0 = a0 + 8'h13; b0 = b0 ^ 8'h5A; end
      else        begin in_valid1 = ~in_valid1; a1 = a1 + 8'h13; b1 = b1 ^ 8'h5A; end
      @(posedge clk); #1;
      check("bp_result_stable", (u == 0) ? result0 : result1, er);
      check("bp_flags_stable", (u == 0) ? {cout0, ovf0, zero0} : {cout1, ovf1, zero1}, {ec, eo, ez});
      check("bp_out_valid", (u == 0) ? out_valid0 : out_valid1, 1);
      check("bp_in_ready", (u == 0) ? in_ready0 : in_ready1, 0);
    end
    if (u == 0) begin out_ready0 = 1'b1; in_valid0 = (bp > 0); end
    else        begin out_ready1 = 1'b1; in_valid1 = (bp > 0); end
    @(posedge clk); #1;
    if (u == 0) begin out_ready0 = 1'b0; in_valid0 = 1'b0; end
    else        begin out_ready1 = 1'b0; in_valid1 = 1'b0; end
    gv = (u == 0) ? out_valid0 : out_valid1;
    gi = (u == 0) ? in_ready0 : in_ready1;
    check("out_valid_after_handshake", gv, 0);
    check("in_ready_after_handshake", gi, 1);
    $display("op u%0d a=%02h b=%02h op=%03b -> result=%02h cout=%0b ovf=%0b zero=%0b lat=%0d",
             u, ta, tbv, top, gr, gc, go, gz, lat);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready0, 1);
    check("rst_out_valid", out_valid0, 0);
    check("rst_result", result0, 0);
    check("rst_flags", {cout0, ovf0, zero0}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(0, 8'h7F, 8'h01, 3'b010, 8'h80, 1'b0, 1'b1, 1'b0, 5, 0);
    run_op(0, 8'h00, 8'h01, 3'b110, 8'hFF, 1'b0, 1'b0, 1'b0, 5, 0);
    run_op(0, 8'hFE, 8'h03, 3'b111, 8'h01, 1'b1, 1'b0, 1'b0, 5, 0);
    run_op(0, 8'h80, 8'h7F, 3'b111, 8'h01, 1'b1, 1'b1, 1'b0, 5, 0);
    run_op(0, 8'h03, 8'hFE, 3'b111, 8'h00, 1'b0, 1'b0, 1'b1, 5, 0);
    run_op(0, 8'h0F, 8'hA0, 3'b001, 8'hAF, 1'b0, 1'b0, 1'b0, 5, 0);
    run_op(0, 8'hC6, 8'h5C, 3'b000, 8'h44, 1'b0, 1'b0, 1'b0, 5, 0);
    run_op(0, 8'hFF, 8'h01, 3'b010, 8'h00, 1'b1, 1'b0, 1'b1, 5, 0);
    run_op(0, 8'hFF, 8'hFF, 3'b101, 8'h00, 1'b0, 1'b0, 1'b1, 5, 0);
    run_op(0, 8'h05, 8'h05, 3'b110, 8'h00, 1'b1, 1'b0, 1'b1, 5, 3);

    // Reset while RUN is on chunk 2.
    a0 = 8'h55; b0 = 8'h0F; op0 = 3'b010; in_valid0 = 1'b1;
    @(posedge clk); #1;
    in_valid0 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid0, 0);
    check("midrst_result", result0, 0);
    check("midrst_flags", {cout0, ovf0, zero0}, 0);
    check("midrst_in_ready", in_ready0, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("postrst_in_ready", in_ready0, 1);
    run_op(0, 8'h10, 8'h22, 3'b010, 8'h32, 1'b0, 1'b0, 1'b0, 5, 0);

    run_op(1, 8'hF0, 8'h3C, 3'b000, 8'h30, 1'b0, 1'b0, 1'b0, 2, 0);
    run_op(1, 8'h12, 8'h34, 3'b011, 8'h00, 1'b0, 1'b0, 1'b1, 2, 0);
    run_op(1, 8'h7F, 8'h01, 3'b010, 8'h80, 1'b0, 1'b1, 1'b0, 2, 0);
    run_op(1, 8'h80, 8'h7F, 3'b111, 8'h01, 1'b1, 1'b1, 1'b0, 2, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
